// File: rtl/vga_embarcacao_n.sv
// Per-ship VGA overlay renderer: latches ship cell codes, converts them to pixel
// boxes during vertical blanking, and draws intact/hit cells with a blinking colour.
module vga_embarcacao_n #(
  parameter int unsigned TAM        = 5,
  parameter logic [2:0]  COR        = 3'b010,
  parameter int unsigned LARGURA    = 54,
  parameter int unsigned ALTURA     = 49,
  parameter int unsigned PASSO_X    = 62,
  parameter int unsigned PASSO_Y    = 57,
  parameter int unsigned ORIG       = 16,
  parameter int unsigned PISCA_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               areaAtiva,
  input  logic [9:0]         linha,
  input  logic [9:0]         coluna,
  input  logic               quadro,
  input  logic               carga,
  input  logic [8*TAM-1:0]   posicoesEmbarcacao,
  input  logic [TAM-1:0]     atingido,
  output logic               rgb_r,
  output logic               rgb_g,
  output logic               rgb_b,
  output logic               ocupado
);

  localparam int unsigned    K_W    = (TAM > 1) ? $clog2(TAM) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(TAM - 1);

  typedef enum logic {OCIOSO, CONVERTE} estado_t;

  estado_t              estado, prox;
  logic [8*TAM-1:0]     sh_pos, snap_pos;
  logic [TAM-1:0]       sh_hit, snap_hit;
  logic                 pendente;
  logic [K_W-1:0]       k;
  logic [2:0]           n;
  logic [9:0]           esq_acc, cima_acc;
  logic [9:0]           esq_tab  [TAM];
  logic [9:0]           cima_tab [TAM];
  logic [TAM-1:0]       valido, hit_tab;
  logic [PISCA_LOG2:0]  quadros;
  logic [2:0]           pix, rgb_q;
  logic                 achou;

  logic       inicia, celula_fim, cel_valida;
  logic [7:0] cod;
  logic [3:0] cx, cy;
  logic [2:0] passos_x, passos_y;

  // A carga coinciding with quadro feeds the new data straight into the conversion.
  assign inicia = (estado == OCIOSO) && quadro && (pendente || carga);

  assign cod        = snap_pos[{k, 3'b000} +: 8];
  assign cx         = cod[3:0];
  assign cy         = cod[7:4];
  assign cel_valida = (cx >= 4'd1) && (cx <= 4'd8) && (cy >= 4'd1) && (cy <= 4'd8);
  assign passos_x   = cel_valida ? 3'(cx - 4'd1) : 3'd0;
  assign passos_y   = cel_valida ? 3'(4'd8 - cy) : 3'd0;
  assign celula_fim = (n >= passos_x) && (n >= passos_y);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox;
  end

  // NOTE: every always_comb output gets a default first, otherwise a path that
  // skips the assignment infers a latch.
  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:   if (inicia) prox = CONVERTE;
      CONVERTE: if (celula_fim && (k == K_LAST)) prox = OCIOSO;
      default:  prox = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado == CONVERTE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_pos   <= '0;
      sh_hit   <= '0;
      pendente <= 1'b0;
      k        <= '0;
      n        <= '0;
      esq_acc  <= 10'(ORIG);
      cima_acc <= 10'(ORIG);
      valido   <= '0;
      quadros  <= '0;
      rgb_q    <= 3'b000;
    end else begin
      rgb_q <= pix;
      if (quadro) quadros <= quadros + 1'b1;
      if (carga) begin
        sh_pos <= posicoesEmbarcacao;
        sh_hit <= atingido;
      end
      // Cleared on entry so a carga arriving mid-conversion queues another pass.
      if (inicia)     pendente <= 1'b0;
      else if (carga) pendente <= 1'b1;

      if (inicia) begin
        k        <= '0;
        n        <= '0;
        esq_acc  <= 10'(ORIG);
        cima_acc <= 10'(ORIG);
      end else if (estado == CONVERTE) begin
        if (celula_fim) begin
          valido[k] <= cel_valida;
          k         <= (k == K_LAST) ? '0 : k + 1'b1;
          n         <= '0;
          esq_acc   <= 10'(ORIG);
          cima_acc  <= 10'(ORIG);
        end else begin
          n <= n + 3'd1;
          if (n < passos_x) esq_acc  <= esq_acc  + 10'(PASSO_X);
          if (n < passos_y) cima_acc <= cima_acc + 10'(PASSO_Y);
        end
      end
    end
  end

  // NOTE: table contents and the snapshot carry no reset; valido alone gates
  // their use, so clearing it is enough to blank the display.
  always_ff @(posedge clk) begin
    if (inicia) begin
      snap_pos <= carga ? posicoesEmbarcacao : sh_pos;
      snap_hit <= carga ? atingido : sh_hit;
    end
    if ((estado == CONVERTE) && celula_fim) begin
      esq_tab[k]  <= esq_acc;
      cima_tab[k] <= cima_acc;
      hit_tab[k]  <= snap_hit[k];
    end
  end

  // Borders excluded; the lowest-index cell wins where cells overlap.
  always_comb begin
    pix   = 3'b000;
    achou = 1'b0;
    for (int i = 0; i < TAM; i++) begin
      if (!achou && valido[i]
          && ({1'b0, coluna} > {1'b0, esq_tab[i]})
          && ({1'b0, coluna} < {1'b0, esq_tab[i]} + 11'(LARGURA))
          && ({1'b0, linha}  > {1'b0, cima_tab[i]})
          && ({1'b0, linha}  < {1'b0, cima_tab[i]} + 11'(ALTURA))) begin
        achou = 1'b1;
        pix   = (hit_tab[i] && quadros[PISCA_LOG2]) ? 3'b100 : COR;
      end
    end
    if (!areaAtiva) pix = 3'b000;
  end

  assign {rgb_r, rgb_g, rgb_b} = rgb_q;

endmodule

// File: tb/tb_vga_embarcacao_n.sv
// Self-checking bench for vga_embarcacao_n: directed and random ships compared
// against an arithmetic model of the displayed ship, blink phase and load queue.
module tb_vga_embarcacao_n;

  localparam int TAM = 5;
  localparam int PL  = 1;
  localparam int FMOD = 1 << (PL + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             areaAtiva = 1'b0;
  logic [9:0]       linha = '0;
  logic [9:0]       coluna = '0;
  logic             quadro = 1'b0;
  logic             carga = 1'b0;
  logic [8*TAM-1:0] posicoesEmbarcacao = '0;
  logic [TAM-1:0]   atingido = '0;
  logic             rgb_r, rgb_g, rgb_b, ocupado;
  logic [2:0]       rgb;

  assign rgb = {rgb_r, rgb_g, rgb_b};

  vga_embarcacao_n #(.TAM(TAM), .PISCA_LOG2(PL)) dut (
    .clk(clk), .rst_n(rst_n), .areaAtiva(areaAtiva), .linha(linha),
    .coluna(coluna), .quadro(quadro), .carga(carga),
    .posicoesEmbarcacao(posicoesEmbarcacao), .atingido(atingido),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queued (shadow) ship, ship being converted, ship on display, frame count.
  logic [8*TAM-1:0] shw_pos, conv_pos, disp_pos;
  logic [TAM-1:0]   shw_hit, conv_hit, disp_hit;
  bit               pending;
  int               frames;

  task automatic model_reset();
    shw_pos = '0; conv_pos = '0; disp_pos = '0;
    shw_hit = '0; conv_hit = '0; disp_hit = '0;
    pending = 1'b0;
    frames  = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cell_ok(int x, int y);
    return (x >= 1) && (x <= 8) && (y >= 1) && (y <= 8);
  endfunction

  function automatic logic [2:0] exp_pix(int l, int c, bit a);
    int x, y, esq, cima;
    bit fase;
    fase = ((frames >> PL) & 1) == 1;
    if (!a) return 3'b000;
    for (int i = 0; i < TAM; i++) begin
      x = int'(disp_pos[8*i +: 4]);
      y = int'(disp_pos[8*i+4 +: 4]);
      if (cell_ok(x, y)) begin
        esq  = 16 + (x - 1) * 62;
        cima = 16 + (8 - y) * 57;
        if (c > esq && c < esq + 54 && l > cima && l < cima + 49)
          return (disp_hit[i] && fase) ? 3'b100 : 3'b010;
      end
    end
    return 3'b000;
  endfunction

  task automatic chk_pix(input string tag, input int l, input int c, input bit a);
    logic [2:0] e;
    linha = 10'(l); coluna = 10'(c); areaAtiva = a;
    e = exp_pix(l, c, a);
    tick();
    check(tag, 32'(rgb), 32'(e));
  endtask

  // Probe the centre of every valid cell on display, plus a few random pixels.
  task automatic chk_ship(input string tag, input int n_rnd);
    int x, y;
    for (int i = 0; i < TAM; i++) begin
      x = int'(disp_pos[8*i +: 4]);
      y = int'(disp_pos[8*i+4 +: 4]);
      if (cell_ok(x, y))
        chk_pix($sformatf("%s_c%0d", tag, i), 16 + (8 - y) * 57 + 24, 16 + (x - 1) * 62 + 27, 1'b1);
    end
    for (int j = 0; j < n_rnd; j++)
      chk_pix($sformatf("%s_r%0d", tag, j), int'($urandom_range(0, 479)),
              int'($urandom_range(0, 639)), ($urandom_range(0, 7) != 0));
  endtask

  task automatic do_carga(input logic [8*TAM-1:0] pos, input logic [TAM-1:0] hit);
    posicoesEmbarcacao = pos; atingido = hit; carga = 1'b1;
    tick();
    carga = 1'b0;
    shw_pos = pos; shw_hit = hit; pending = 1'b1;
  endtask

  task automatic do_quadro(input string tag, input bit with_carga,
                           input logic [8*TAM-1:0] pos, input logic [TAM-1:0] hit);
    bit starts;
    if (with_carga) begin
      posicoesEmbarcacao = pos; atingido = hit; carga = 1'b1;
    end
    quadro = 1'b1;
    starts = pending || with_carga;
    tick();
    quadro = 1'b0; carga = 1'b0;
    frames = (frames + 1) % FMOD;
    if (with_carga) begin
      shw_pos = pos; shw_hit = hit;
    end
    if (starts) begin
      conv_pos = with_carga ? pos : shw_pos;
      conv_hit = with_carga ? hit : shw_hit;
      pending  = 1'b0;
    end
    check({tag, "_ocupado"}, 32'(ocupado), 32'(starts));
  endtask

  task automatic wait_conv(input string tag);
    int cycles = 0;
    while (ocupado === 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    check({tag, "_done"}, 32'(ocupado), 32'd0);
    check({tag, "_len_ok"}, 32'(cycles <= TAM * 8 + 1), 32'd1);
    disp_pos = conv_pos; disp_hit = conv_hit;
  endtask

  function automatic logic [7:0] rnd_code();
    if ($urandom_range(0, 3) != 0)
      return {4'($urandom_range(1, 8)), 4'($urandom_range(1, 8))};
    return 8'($urandom);
  endfunction

  function automatic logic [8*TAM-1:0] rnd_ship();
    logic [8*TAM-1:0] p;
    for (int i = 0; i < TAM; i++) p[8*i +: 8] = rnd_code();
    return p;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [8*TAM-1:0] ship_a, ship_b, ship_c, ship_d;

  initial begin
    model_reset();
    ship_a = {8'h55, 8'h94, 8'h30, 8'h18, 8'h81};
    ship_b = {8'h00, 8'h00, 8'h00, 8'h44, 8'h27};
    ship_c = {8'h11, 8'h22, 8'h33, 8'h81, 8'h81};
    ship_d = {8'h88, 8'h77, 8'h66, 8'h05, 8'hA2};

    // Reset state
    #12;
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    #11 rst_n = 1'b1;
    chk_pix("idle_40_40", 40, 40, 1'b1);
    chk_pix("idle_440_470", 440, 470, 1'b1);
    do_quadro("q_no_load", 1'b0, '0, '0);
    chk_pix("idle_after_q", 40, 40, 1'b1);

    // Ship A: X=1,Y=8 / X=8,Y=1 / invalid codes / X=5,Y=5
    do_carga(ship_a, '0);
    do_quadro("qa", 1'b0, '0, '0);
    wait_conv("qa");
    chk_pix("a_40_40", 40, 40, 1'b1);
    check("a_40_40_const", 32'(rgb), 32'h2);
    chk_pix("a_col16_border", 40, 16, 1'b1);
    chk_pix("a_col70_border", 40, 70, 1'b1);
    chk_pix("a_col17", 40, 17, 1'b1);
    chk_pix("a_col69", 40, 69, 1'b1);
    chk_pix("a_lin16_border", 16, 40, 1'b1);
    chk_pix("a_lin65_border", 65, 40, 1'b1);
    chk_pix("a_440_470", 440, 470, 1'b1);
    check("a_440_470_const", 32'(rgb), 32'h2);
    chk_pix("a_inactive", 40, 40, 1'b0);
    chk_pix("a_col_x4_y9", 40, 230, 1'b1);
    chk_ship("a", 8);

    // Blink: hit on cell 0, phase flips every 2 frames
    do_quadro("blk_load", 1'b1, ship_a, 5'b00001);
    wait_conv("blk_load");
    for (int f = 0; f < 6; f++) begin
      chk_pix($sformatf("blink_f%0d", f), 40, 40, 1'b1);
      chk_pix($sformatf("blink_intact_f%0d", f), 440, 470, 1'b1);
      do_quadro($sformatf("blink_q%0d", f), 1'b0, '0, '0);
    end

    // carga without quadro leaves the display untouched
    do_carga(ship_b, 5'b00011);
    for (int c = 0; c < 20; c++) tick();
    chk_ship("b_pending_old", 4);
    do_quadro("qb", 1'b0, '0, '0);
    wait_conv("qb");
    chk_ship("b", 6);

    // carga during conversion queues the next ship
    do_carga(ship_c, 5'b10101);
    do_quadro("qc", 1'b0, '0, '0);
    tick(); tick();
    do_carga(ship_d, 5'b01010);
    wait_conv("qc");
    chk_ship("c", 4);
    do_quadro("qd", 1'b0, '0, '0);
    wait_conv("qd");
    chk_ship("d", 4);

    // Randomized ships, split and same-cycle carga/quadro
    for (int it = 0; it < 25; it++) begin
      logic [8*TAM-1:0] p;
      logic [TAM-1:0]   h;
      p = rnd_ship();
      h = TAM'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_carga(p, h);
        for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick();
        do_quadro($sformatf("rq%0d", it), 1'b0, '0, '0);
      end else begin
        do_quadro($sformatf("rq%0d", it), 1'b1, p, h);
      end
      wait_conv($sformatf("rq%0d", it));
      chk_ship($sformatf("rnd%0d", it), 5);
    end

    // Reset asserted mid-conversion
    do_carga(ship_a, 5'b11111);
    do_quadro("qrst", 1'b0, '0, '0);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_ocupado", 32'(ocupado), 32'd0);
    check("midrst_rgb", 32'(rgb), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk_pix("postrst_40_40", 40, 40, 1'b1);
    chk_pix("postrst_440_470", 440, 470, 1'b1);
    do_quadro("postrst_q", 1'b0, '0, '0);
    chk_pix("postrst_q_40_40", 40, 40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
